// File: rtl/switch_alloc_pkg.sv
// Shared types and constants for the NoC switch allocator.
// Optional PMU counters are enabled with SWITCH_ALLOC_PMU_EN.
package switch_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_t;

  localparam int PMU_CNT_W = 16;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/handshake bundle between route computation, input queues and the allocator.
// PMU signals exist only when SWITCH_ALLOC_PMU_EN is defined.
interface switch_allocator_if
  import switch_alloc_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 5,
  parameter int CH_W           = $clog2(CHANNEL_NUMBER)
);
  logic [CHANNEL_NUMBER-1:0]      req_valid_i;
  logic [CHANNEL_NUMBER*CH_W-1:0] req_port_i;
  logic [CHANNEL_NUMBER-1:0]      in_valid_i;
  logic [CHANNEL_NUMBER-1:0]      in_last_i;
  logic [CHANNEL_NUMBER-1:0]      out_ready_i;
  logic [CHANNEL_NUMBER-1:0]      in_grant_o;
  logic [CHANNEL_NUMBER-1:0]      out_active_o;
  logic [CHANNEL_NUMBER*CH_W-1:0] out_sel_o;

`ifdef SWITCH_ALLOC_PMU_EN
  logic                                pmu_clear_i;
  logic [CHANNEL_NUMBER*PMU_CNT_W-1:0] pmu_pkt_cnt_o;
  logic [CHANNEL_NUMBER*PMU_CNT_W-1:0] pmu_stall_cnt_o;

  modport master (
    output req_valid_i, req_port_i, in_valid_i, in_last_i, out_ready_i, pmu_clear_i,
    input  in_grant_o, out_active_o, out_sel_o, pmu_pkt_cnt_o, pmu_stall_cnt_o
  );
  modport slave (
    input  req_valid_i, req_port_i, in_valid_i, in_last_i, out_ready_i, pmu_clear_i,
    output in_grant_o, out_active_o, out_sel_o, pmu_pkt_cnt_o, pmu_stall_cnt_o
  );
`else
  modport master (
    output req_valid_i, req_port_i, in_valid_i, in_last_i, out_ready_i,
    input  in_grant_o, out_active_o, out_sel_o
  );
  modport slave (
    input  req_valid_i, req_port_i, in_valid_i, in_last_i, out_ready_i,
    output in_grant_o, out_active_o, out_sel_o
  );
`endif

endinterface

// File: rtl/switch_allocator_rr_picker.sv
// Round-robin picker: first set request bit scanning upward from ptr_i+1 with wrap-around.
module rr_picker #(
  parameter int CHANNEL_NUMBER = 5,
  parameter int CH_W           = $clog2(CHANNEL_NUMBER)
) (
  input  logic [CHANNEL_NUMBER-1:0] req_i,
  input  logic [CH_W-1:0]           ptr_i,
  output logic [CHANNEL_NUMBER-1:0] gnt_o,
  output logic [CH_W-1:0]           idx_o
);

  always_comb begin
    logic            found;
    logic [CH_W-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= CHANNEL_NUMBER; k++) begin
      cand = CH_W'((int'(ptr_i) + k) % CHANNEL_NUMBER);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole output-port allocator: one round-robin lock per output, held until TLAST transfers.
// Define SWITCH_ALLOC_PMU_EN to add per-output packet and stall counters.
module switch_allocator
  import switch_alloc_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 5,
  parameter int CH_W           = $clog2(CHANNEL_NUMBER)
) (
  input logic               clk_i,
  input logic               rst_i,
  switch_allocator_if.slave bus
);

  localparam logic [CH_W-1:0] PTR_RST = CH_W'(CHANNEL_NUMBER - 1);

  logic [CHANNEL_NUMBER-1:0]                     locked;
  logic [CHANNEL_NUMBER-1:0]                     last_xfer;
  logic [CHANNEL_NUMBER-1:0]                     in_grant;
  logic [CHANNEL_NUMBER-1:0][CH_W-1:0]           owner_sel;
  logic [CHANNEL_NUMBER-1:0][CHANNEL_NUMBER-1:0] own_hit;

`ifdef SWITCH_ALLOC_PMU_EN
  function automatic logic [PMU_CNT_W-1:0] sat_inc(input logic [PMU_CNT_W-1:0] v);
    return (&v) ? v : v + PMU_CNT_W'(1);
  endfunction
`endif

  // An input is busy while any output is locked to it; busy inputs are masked from arbitration.
  for (genvar c = 0; c < CHANNEL_NUMBER; c++) begin : g_in
    for (genvar o = 0; o < CHANNEL_NUMBER; o++) begin : g_hit
      assign own_hit[c][o] = locked[o] && (owner_sel[o] == CH_W'(c));
    end
    assign in_grant[c] = |own_hit[c];
  end

  for (genvar o = 0; o < CHANNEL_NUMBER; o++) begin : g_out
    alloc_state_t              state_q, state_d;
    logic [CH_W-1:0]           owner_q, owner_d;
    logic [CH_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]           pick_idx;
    logic [CHANNEL_NUMBER-1:0] cand;
    logic [CHANNEL_NUMBER-1:0] pick_gnt;
    logic                      beat;

    for (genvar c = 0; c < CHANNEL_NUMBER; c++) begin : g_cand
      assign cand[c] = bus.req_valid_i[c] && !in_grant[c] &&
                       (bus.req_port_i[c*CH_W +: CH_W] == CH_W'(o));
    end

    rr_picker #(
      .CHANNEL_NUMBER(CHANNEL_NUMBER),
      .CH_W          (CH_W)
    ) u_pick (
      .req_i(cand),
      .ptr_i(rr_ptr_q),
      .gnt_o(pick_gnt),
      .idx_o(pick_idx)
    );

    assign locked[o]    = (state_q == ALLOC_LOCKED);
    assign owner_sel[o] = owner_q;
    assign beat         = bus.in_valid_i[owner_q] && bus.out_ready_i[o];
    assign last_xfer[o] = locked[o] && beat && bus.in_last_i[owner_q];

    // Owner returns to 0 on release so out_sel reads 0 while idle.
    always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
        ALLOC_IDLE: begin
          if (|pick_gnt) begin
            state_d = ALLOC_LOCKED;
            owner_d = pick_idx;
          end
        end
        ALLOC_LOCKED: begin
          if (last_xfer[o]) begin
            state_d  = ALLOC_IDLE;
            owner_d  = '0;
            rr_ptr_d = owner_q;
          end
        end
        default: state_d = ALLOC_IDLE;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q  <= ALLOC_IDLE;
        owner_q  <= '0;
        rr_ptr_q <= PTR_RST;
      end else begin
        state_q  <= state_d;
        owner_q  <= owner_d;
        rr_ptr_q <= rr_ptr_d;
      end
    end

`ifdef SWITCH_ALLOC_PMU_EN
    logic [PMU_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [PMU_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
      pkt_cnt_d   = pkt_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (bus.pmu_clear_i) begin
        pkt_cnt_d   = '0;
        stall_cnt_d = '0;
      end else begin
        if (last_xfer[o]) pkt_cnt_d = sat_inc(pkt_cnt_q);
        if (locked[o] && bus.in_valid_i[owner_q] && !bus.out_ready_i[o])
          stall_cnt_d = sat_inc(stall_cnt_q);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pkt_cnt_q   <= '0;
        stall_cnt_q <= '0;
      end else begin
        pkt_cnt_q   <= pkt_cnt_d;
        stall_cnt_q <= stall_cnt_d;
      end
    end

    assign bus.pmu_pkt_cnt_o[o*PMU_CNT_W +: PMU_CNT_W]   = pkt_cnt_q;
    assign bus.pmu_stall_cnt_o[o*PMU_CNT_W +: PMU_CNT_W] = stall_cnt_q;
`endif
  end

  assign bus.in_grant_o   = in_grant;
  assign bus.out_active_o = locked;
  assign bus.out_sel_o    = owner_sel;

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-router output-port allocator for the AXI-Stream NoC router. It sits between route computation (which supplies a requested output port for each input queue's head packet) and the crossbar/output muxing.
- Each output port is granted to one input channel, chosen round-robin, and held for a whole packet until the TLAST beat is transferred. Crossbar select vectors are produced per output.
- Allocation is packet-granular (wormhole). There are no credits; backpressure is taken directly from output TREADY.

Parameters:
- CHANNEL_NUMBER, 5, number of input channels and of output ports (local + N/E/S/W).
- CH_W, $clog2(CHANNEL_NUMBER), width of one port/channel index (3 at default).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  CHANNEL_NUMBER  input c has a head packet requesting an output.
- req_port_i  input  CHANNEL_NUMBER*CH_W  requested output index of input c, in slice [c*CH_W +: CH_W].
- in_valid_i  input  CHANNEL_NUMBER  TVALID of each input queue head.
- in_last_i  input  CHANNEL_NUMBER  TLAST of each input queue head.
- out_ready_i  input  CHANNEL_NUMBER  TREADY of each output port.
- in_grant_o  output  CHANNEL_NUMBER  input c currently owns some output.
- out_active_o  output  CHANNEL_NUMBER  output o is locked to an owner.
- out_sel_o  output  CHANNEL_NUMBER*CH_W  owner index of output o, in slice [o*CH_W +: CH_W].

Behaviour:
- **Clock and reset:** one clock, clk_i. rst_i is asynchronous and active-high.
- **Reset values:**
  - All outputs are 0.
  - Every output FSM is IDLE.
  - Every rr_ptr[o] resets to CHANNEL_NUMBER-1, so input 0 has first priority.
- **Per-output FSM, two states:**
  - IDLE:
    - Candidate set = inputs c with req_valid_i[c], req_port_i[c]==o, and in_grant_o[c]==0.
    - If the set is non-empty, pick the first candidate scanning from rr_ptr[o]+1 upward with wrap-around at CHANNEL_NUMBER-1 → 0.
    - Register the pick as owner and move to LOCKED.
    - Grant latency is 1 cycle: out_active_o, out_sel_o and in_grant_o assert the cycle after the request is seen.
  - LOCKED:
    - A beat transfers when in_valid_i[owner] && out_ready_i[o].
    - A transfer with in_last_i[owner]=1 moves the FSM to IDLE and sets rr_ptr[o] <= owner.
    - Other transfers keep the lock.
    - The owner's req_valid_i and req_port_i are ignored while locked.
- **Release:** takes effect next cycle, so there is one idle cycle per output between packets. Re-arbitration starts in the IDLE cycle.
- **Simultaneous allocation:** several outputs may allocate in the same cycle. An input may request only one output, and locked inputs are masked, so no input is ever granted two outputs.
- **Out-of-range requests:** req_port_i >= CHANNEL_NUMBER matches no output and is never granted.
- **Single-beat packet:** a packet with TLAST on its first beat grants and releases normally (LOCKED for exactly the transfer cycle(s)).
- **Stalls:** in_valid_i low, or out_ready_i low, holds the lock indefinitely. No timeout.
- **Reset mid-packet:** all locks clear immediately (asynchronous) and rr_ptr values reinitialise.
- **Output stability:** out_sel_o is stable for the whole lock. Its value in IDLE is 0 but is qualified by out_active_o.

Optional Feature:
- Macro: SWITCH_ALLOC_PMU_EN.
- Defined: adds the following ports:
  - pmu_clear_i (input, 1).
  - pmu_pkt_cnt_o (output, CHANNEL_NUMBER*16): per-output count of TLAST transfers, saturating at 16'hFFFF.
  - pmu_stall_cnt_o (output, CHANNEL_NUMBER*16): per-output count of cycles with LOCKED && in_valid_i[owner] && !out_ready_i[o], saturating.
- Counter clear: counters clear on rst_i or on pmu_clear_i. pmu_clear_i has priority over an increment in the same cycle.
- Undefined: none of these ports or counters exist; allocation behaviour is identical in both builds.

Decomposition:
- Shared package switch_alloc_pkg:
  - alloc_state_t enum {ALLOC_IDLE, ALLOC_LOCKED}.
  - PMU_CNT_W = 16.
  - rr_pick function, or its interface constants.
- One natural sub-module: rr_picker.
  - Combinational: CHANNEL_NUMBER-bit request mask plus a CH_W pointer → one-hot grant and index.
  - Instantiated once per output.

Test Plan:
- **First grant after reset:** reset, then req_valid_i=5'b00011, both requesting port 2. → Cycle+1: out_active_o[2]=1, out_sel_o[2]=0, in_grant_o=5'b00001. Input 1 is not granted.
- **Round-robin:** input 0 sends a 3-beat packet (TLAST on beat 3) while input 1 keeps requesting port 2. → Output 2 goes IDLE for one cycle, then out_sel_o[2]=1. Repeat with input 0 re-requesting → next owner is 0. Grants alternate 0,1,0,1.
- **Backpressure hold:** locked owner 3 on port 4, out_ready_i[4]=0 for 10 cycles with in_valid_i[3]=1. → Lock held, out_sel_o[4]=3 throughout.
- **Parallel allocation:** inputs 0..4 request ports 4,3,2,1,0 in the same cycle. → All five outputs active next cycle with out_sel_o={0,1,2,3,4} reversed per port. in_grant_o=5'b11111.
- **Out-of-range and reset:** req_port_i[1]=7 → no grant ever. Assert rst_i mid-packet → out_active_o=0 immediately. After release, input 0 wins a contended port.
- **PMU** (with SWITCH_ALLOC_PMU_EN):
  - Two packets through port 0 plus 4 stalled cycles → pmu_pkt_cnt_o[0]=2, pmu_stall_cnt_o[0]=4.
  - Pulse pmu_clear_i → both read 0 next cycle.
